led_pwm_fader: RTL and testbench
================================

Name: led_pwm_fader

Overview:
Downstream LED output stage. It consumes the level "LED on/off" request produced by the blink-pattern counters and drives the physical LED pin through a PWM, replacing hard switching with a linear brightness fade-in and fade-out. It contains a free-running PWM counter, a fade-step prescaler and a 4-state fade FSM. Duty updates only at PWM period boundaries, so the output is glitch-free.

Parameters:
PWM_BITS, 8, PWM counter width; PWM period = 2^PWM_BITS clk cycles.
STEP_PERIODS, 1024, full PWM periods per 1-LSB duty step while fading (>=1).
MAX_DUTY, 255, duty in the ON state (1 .. 2^PWM_BITS-1).

Ports:
clk  in  1  system clock (100 MHz on board)
rst  in  1  reset, asynchronous, active-high
req  in  1  requested LED state (level); 1 = fade to on, 0 = fade to off
en   in  1  global enable; 0 = force dark immediately
led  out 1  PWM LED drive, registered
duty out PWM_BITS  current linear duty value
busy out 1  1 while fading (RISING or FALLING)
state out 2  FSM state: OFF=0, RISING=1, ON=2, FALLING=3

Behaviour:
- Reset (async, rst=1): state=OFF, duty=0, pwm_cnt=0, step_cnt=0, led=0, busy=0. All regs clear immediately and stay clear while rst is high.
- pwm_cnt: free-running PWM_BITS counter that wraps all-ones->0. pwm_wrap = (pwm_cnt == all-ones). It runs regardless of en or state.
- step_cnt: width clog2(STEP_PERIODS), min 1. Cleared on every state change and while in OFF/ON. Increments on pwm_wrap.
- step_tick = pwm_wrap && step_cnt == STEP_PERIODS-1. On step_tick, step_cnt returns to 0.
- First step after entering a fade state occurs between (STEP_PERIODS-1)*2^PWM_BITS+1 and STEP_PERIODS*2^PWM_BITS cycles after entry.
- FSM transitions (evaluated every clk, only when en=1):
  OFF: req=1 -> RISING.
  RISING: step_tick -> duty+1; if duty+1 == MAX_DUTY, go to ON on the same edge. req=0 -> FALLING next edge, duty kept.
  ON: duty held at MAX_DUTY; req=0 -> FALLING.
  FALLING: step_tick -> duty-1; if duty-1 == 0, go to OFF on the same edge. req=1 -> RISING next edge, duty kept.
  If req reverses on the same cycle as step_tick, the reversal wins and duty does not change that edge.
- Duty saturation: duty never exceeds MAX_DUTY and never goes below 0. No wrap-around.
- en=0: on the next edge, state=OFF, duty=0, step_cnt=0, led=0. req is ignored while en=0. On en returning to 1, normal operation resumes from OFF.
- duty_eff = duty, or the gamma-mapped value when the optional feature is compiled in.
- led output, registered with 1-cycle latency: led <= en && (duty_eff == 2^PWM_BITS-1 || pwm_cnt < duty_eff).
  duty_eff=0 -> constant 0. duty_eff=all-ones -> constant 1. Otherwise exactly duty_eff high cycles per period, starting at pwm_cnt=0.
- Because duty changes only on step_tick, which coincides with pwm_wrap, every PWM period uses a single duty value.
- busy = (state==RISING || state==FALLING), driven combinationally from the state register.
- Full fade time = MAX_DUTY * STEP_PERIODS * 2^PWM_BITS cycles (defaults: ~0.67 s at 100 MHz).

Optional Feature:
LED_PWM_GAMMA_EN:
- Defined: duty_eff = (duty*(duty+1)) >> PWM_BITS, using a 2*PWM_BITS-wide product. This is a perceptual square-law mapping: 0->0 and all-ones->all-ones are preserved, and it is monotonic.
- Undefined: duty_eff = duty and no multiplier is synthesized.
- The duty port always reports the linear value in both builds.

Test Plan:
(All with PWM_BITS=4, STEP_PERIODS=2, MAX_DUTY=15 unless noted.)
1. Reset: pulse rst asynchronously mid-fade (between clk edges) -> led, duty, busy go to 0 and state to OFF before the next edge; they stay there while rst=1.
2. Fade-up: req 0->1 from OFF -> busy=1 and state=RISING after 1 edge; duty increments every 32 cycles; state=ON with duty=15 within 480 cycles; led then constant 1.
3. PWM shape: freeze in ON with MAX_DUTY=5 -> every 16-cycle period has exactly 5 consecutive led=1 cycles, starting 1 cycle after pwm_cnt=0.
4. Reversal: drop req when duty=7 in RISING -> state=FALLING next edge; duty never exceeds 7 and reaches 0 after 7 step_ticks; then state=OFF, busy=0, led constant 0.
5. Enable: en=0 while ON -> next edge led=0, duty=0, state=OFF; toggling req while en=0 has no effect; en=1 with req=1 -> RISING.
6. Gamma (LED_PWM_GAMMA_EN defined): duty=8 -> 4 high cycles per period; duty=15 -> constant 1; duty=1 -> constant 0.

Source files
------------

// File: rtl/led_pwm_fader.sv
// PWM LED output stage that fades brightness linearly up and down on a level request.
// Optional square-law brightness mapping is compiled in with LED_PWM_GAMMA_EN.
module led_pwm_fader #(
   parameter int unsigned PWM_BITS     = 8,
   parameter int unsigned STEP_PERIODS = 1024,
   parameter int unsigned MAX_DUTY     = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_i,
   input  logic                en_i,
   output logic                led_o,
   output logic [PWM_BITS-1:0] duty_o,
   output logic                busy_o,
   output logic [1:0]          state_o
);

   localparam int unsigned StepW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
   localparam logic [StepW-1:0]    StepLast = StepW'(STEP_PERIODS - 1);
   localparam logic [PWM_BITS-1:0] DutyMax  = PWM_BITS'(MAX_DUTY);

   typedef enum logic [1:0] {
      StOff     = 2'd0,
      StRising  = 2'd1,
      StOn      = 2'd2,
      StFalling = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic [PWM_BITS-1:0] pwm_cnt_q;
   logic [StepW-1:0]    step_cnt_q, step_cnt_d;
   logic                led_q, led_d;
   logic                pwm_wrap;
   logic                step_tick;
   logic [PWM_BITS-1:0] duty_eff;

   assign pwm_wrap  = (pwm_cnt_q == '1);
   assign step_tick = pwm_wrap && (step_cnt_q == StepLast);

`ifdef LED_PWM_GAMMA_EN
   logic [2*PWM_BITS-1:0] duty_wide;
   logic [2*PWM_BITS-1:0] gamma_prod;
   assign duty_wide  = {{PWM_BITS{1'b0}}, duty_q};
   assign gamma_prod = duty_wide * (duty_wide + (2*PWM_BITS)'(1));
   assign duty_eff   = gamma_prod[2*PWM_BITS-1:PWM_BITS];
`else
   assign duty_eff = duty_q;
`endif

   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      if (!en_i) begin
         state_d = StOff;
         duty_d  = '0;
      end else begin
         unique case (state_q)
            StOff: begin
               if (req_i) state_d = StRising;
            end
            StRising: begin
               // A reversal takes priority over a coincident step.
               if (!req_i) begin
                  state_d = StFalling;
               end else if (step_tick) begin
                  if (duty_q < DutyMax) duty_d = duty_q + 1'b1;
                  if (duty_q + 1'b1 >= DutyMax || duty_q >= DutyMax) state_d = StOn;
               end
            end
            StOn: begin
               if (!req_i) state_d = StFalling;
            end
            StFalling: begin
               if (req_i) begin
                  state_d = StRising;
               end else if (step_tick) begin
                  if (duty_q != '0) duty_d = duty_q - 1'b1;
                  if (duty_q <= PWM_BITS'(1)) state_d = StOff;
               end
            end
            default: state_d = StOff;
         endcase
      end
   end

   always_comb begin
      step_cnt_d = step_cnt_q;
      if (!en_i || state_d != state_q || state_q == StOff || state_q == StOn) begin
         step_cnt_d = '0;
      end else if (pwm_wrap) begin
         step_cnt_d = step_tick ? '0 : step_cnt_q + 1'b1;
      end
   end

   assign led_d = en_i && ((duty_eff == '1) || (pwm_cnt_q < duty_eff));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StOff;
         duty_q     <= '0;
         pwm_cnt_q  <= '0;
         step_cnt_q <= '0;
         led_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         duty_q     <= duty_d;
         pwm_cnt_q  <= pwm_cnt_q + 1'b1;
         step_cnt_q <= step_cnt_d;
         led_q      <= led_d;
      end
   end

   assign led_o   = led_q;
   assign duty_o  = duty_q;
   assign state_o = state_q;
   assign busy_o  = (state_q == StRising) || (state_q == StFalling);

endmodule

// File: tb/tb_led_pwm_fader.sv
// Self-checking bench: two faders (MAX_DUTY 15 and 5) against a cycle-level behavioural model.
module tb_led_pwm_fader;

   localparam int Pb   = 4;
   localparam int Per  = 1 << Pb;
   localparam int Step = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req = 1'b0;
   logic       en  = 1'b0;
   logic       led_w   [2];
   logic [3:0] duty_w  [2];
   logic       busy_w  [2];
   logic [1:0] state_w [2];

   int n_checks = 0;
   int n_pass   = 0;

   int m_max   [2] = '{15, 5};
   int m_state [2];
   int m_duty  [2];
   int m_wraps [2];
   int m_led   [2];
   int m_pwm;

   always #5 clk = ~clk;

   led_pwm_fader #(.PWM_BITS(Pb), .STEP_PERIODS(Step), .MAX_DUTY(15)) u_dut0 (
      .clk(clk), .rst(rst), .req_i(req), .en_i(en),
      .led_o(led_w[0]), .duty_o(duty_w[0]), .busy_o(busy_w[0]), .state_o(state_w[0])
   );

   led_pwm_fader #(.PWM_BITS(Pb), .STEP_PERIODS(Step), .MAX_DUTY(5)) u_dut1 (
      .clk(clk), .rst(rst), .req_i(req), .en_i(en),
      .led_o(led_w[1]), .duty_o(duty_w[1]), .busy_o(busy_w[1]), .state_o(state_w[1])
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic int eff(input int d);
`ifdef LED_PWM_GAMMA_EN
      return (d * (d + 1)) / Per;
`else
      return d;
`endif
   endfunction

   // High cycles per PWM period for a linear duty value.
   function automatic int high_cycles(input int d);
      return (eff(d) == Per - 1) ? Per : eff(d);
   endfunction

   task automatic model_reset();
      m_pwm = 0;
      for (int i = 0; i < 2; i++) begin
         m_state[i] = 0; m_duty[i] = 0; m_wraps[i] = 0; m_led[i] = 0;
      end
   endtask

   task automatic model_edge();
      int s, d, ns, nd;
      bit wrap, tick;
      if (rst) return;
      wrap = (m_pwm == Per - 1);
      for (int i = 0; i < 2; i++) begin
         s = m_state[i]; d = m_duty[i]; ns = s; nd = d;
         tick = wrap && (m_wraps[i] == Step - 1);
         m_led[i] = (en && (eff(d) == Per - 1 || m_pwm < eff(d))) ? 1 : 0;
         if (!en) begin
            ns = 0; nd = 0;
         end else begin
            case (s)
               0: if (req) ns = 1;
               1: if (!req) ns = 3;
                  else if (tick) begin
                     nd = (d + 1 > m_max[i]) ? m_max[i] : d + 1;
                     if (nd == m_max[i]) ns = 2;
                  end
               2: if (!req) ns = 3;
               default: if (req) ns = 1;
                  else if (tick) begin
                     nd = (d > 0) ? d - 1 : 0;
                     if (nd == 0) ns = 0;
                  end
            endcase
         end
         if (!en || ns != s || s == 0 || s == 2) m_wraps[i] = 0;
         else if (wrap) m_wraps[i] = (m_wraps[i] + 1) % Step;
         m_state[i] = ns;
         m_duty[i]  = nd;
      end
      m_pwm = (m_pwm + 1) % Per;
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         check($sformatf("d%0d.state", i), int'(state_w[i]), m_state[i]);
         check($sformatf("d%0d.duty", i), int'(duty_w[i]), m_duty[i]);
         check($sformatf("d%0d.busy", i), int'(busy_w[i]),
               (m_state[i] == 1 || m_state[i] == 3) ? 1 : 0);
         check($sformatf("d%0d.led", i), int'(led_w[i]), m_led[i]);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1 check_all();
   endtask

   task automatic wait_state0(input int st, input int budget);
      for (int k = 0; k < budget && int'(state_w[0]) != st; k++) cyc();
      check("wait_state", int'(state_w[0]), st);
   endtask

   initial begin
      int n;
      model_reset();
      #12;
      check_all();
      repeat (3) cyc();
      rst = 1'b0;
      en  = 1'b1;
      cyc();

      // Fade up to ON, then measure the 5-duty PWM shape.
      req = 1'b1;
      cyc();
      check("rise_busy", int'(busy_w[0]), 1);
      wait_state0(2, 600);
      repeat (20) cyc();
      n = 0;
      for (int k = 0; k < Per; k++) begin
         cyc();
         n += int'(led_w[1]);
      end
      check("pwm5_high", n, high_cycles(5));

      // Fade down, then reverse at duty 7.
      req = 1'b0;
      wait_state0(0, 600);
      req = 1'b1;
      for (int k = 0; k < 300 && int'(duty_w[0]) != 7; k++) cyc();
      check("dut0_duty7", int'(duty_w[0]), 7);
      req = 1'b0;
      cyc();
      check("reverse_fall", int'(state_w[0]), 3);
      wait_state0(0, 400);
      repeat (20) cyc();

      // Asynchronous reset mid-fade.
      req = 1'b1;
      repeat (70) cyc();
      #2 rst = 1'b1;
      #1;
      model_reset();
      check("arst_state", int'(state_w[0]), 0);
      check("arst_duty", int'(duty_w[0]), 0);
      check("arst_busy", int'(busy_w[0]), 0);
      check("arst_led", int'(led_w[0]), 0);
      repeat (3) cyc();
      rst = 1'b0;

      // Enable drop while ON; req ignored while disabled.
      wait_state0(2, 600);
      en = 1'b0;
      cyc();
      check("en_off_state", int'(state_w[0]), 0);
      for (int k = 0; k < 10; k++) begin
         req = ~req;
         cyc();
      end
      en  = 1'b1;
      req = 1'b1;
      cyc();
      check("en_on_rise", int'(state_w[0]), 1);

      // Randomised request and enable activity.
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 59) == 0) req = ~req;
         en = ($urandom_range(0, 399) != 0);
         cyc();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
